// File: rtl/rpll_reconfig_ctrl.sv
// rpll_reconfig_ctrl: rPLL supervisor and dynamic divider reconfiguration.
// The PLL reset is sequenced and LOCK is qualified (sync, debounce, timeout,
// bounded retry). A downstream reset is held until lock is stable, and new
// IDSEL/FBDSEL/ODSEL sets are accepted through a valid/ready handshake.
// Optional feature macro: RPLL_LOL_COUNT_EN adds the lol_count output, which
// counts loss-of-lock recoveries.
module rpll_reconfig_ctrl #(
  parameter logic [5:0] DEF_IDSEL           = 6'd0,
  parameter logic [5:0] DEF_FBDSEL          = 6'd0,
  parameter logic [5:0] DEF_ODSEL           = 6'd0,
  parameter int         RESET_HOLD_CYCLES   = 16,
  parameter int         LOCK_STABLE_CYCLES  = 1024,
  parameter int         LOCK_TIMEOUT_CYCLES = 65535,
  parameter int         MAX_RETRIES         = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       sys_rst,
  output logic       busy,
  output logic       error,
  output logic [1:0] retry_cnt
`ifdef RPLL_LOL_COUNT_EN
  ,
  output logic [7:0] lol_count
`endif
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  // Terminal values: a state lasts exactly N cycles when its counter starts at 0
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    HOLD_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              sync1_q, sync2_q;
  logic              lock_s;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]        retry_q, retry_d;
  logic [5:0]        idsel_q, idsel_d;
  logic [5:0]        fbdsel_q, fbdsel_d;
  logic [5:0]        odsel_q, odsel_d;
  logic              cfg_ready_q, pll_reset_q, locked_q, sys_rst_q, busy_q, error_q;
  logic              lol_evt;

  assign lock_s = sync2_q;

  // Two-flop synchroniser for the asynchronous PLL LOCK
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, retry and divider-latch logic
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    idsel_d  = idsel_q;
    fbdsel_d = fbdsel_q;
    odsel_d  = odsel_q;
    lol_evt  = 1'b0;
    case (state_q)
      HOLD_RST: begin
        if (hold_cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          if (int'(retry_q) < MAX_RETRIES) begin
            state_d = HOLD_RST;
            retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
          end else begin
            state_d = FAIL;
          end
        end
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (stab_cnt_q == STAB_LAST) state_d = LOCKED;
      end
      LOCKED: begin
        // An accepted config wins over a simultaneous lock loss; both restart
        // from HOLD_RST, so only one recovery sequence runs.
        if (cfg_valid && cfg_ready_q) begin
          state_d  = HOLD_RST;
          retry_d  = 2'd0;
          idsel_d  = cfg_idsel;
          fbdsel_d = cfg_fbdsel;
          odsel_d  = cfg_odsel;
        end else if (!lock_s) begin
          state_d = HOLD_RST;
          retry_d = 2'd0;
          lol_evt = 1'b1;
        end
      end
      FAIL: begin
        if (cfg_valid) begin
          state_d  = HOLD_RST;
          retry_d  = 2'd0;
          idsel_d  = cfg_idsel;
          fbdsel_d = cfg_fbdsel;
          odsel_d  = cfg_odsel;
        end
      end
      default: state_d = HOLD_RST;
    endcase
  end

  // Each counter runs only while its state persists, so it is zero on every entry
  always_comb begin
    hold_cnt_d = '0;
    stab_cnt_d = '0;
    tmo_cnt_d  = '0;
    if (state_q == HOLD_RST  && state_d == HOLD_RST)  hold_cnt_d = hold_cnt_q + 1'b1;
    if (state_q == STABLE    && state_d == STABLE)    stab_cnt_d = stab_cnt_q + 1'b1;
    if (state_q == WAIT_LOCK && state_d == WAIT_LOCK) tmo_cnt_d  = tmo_cnt_q + 1'b1;
  end

  // State, counters, dividers and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= HOLD_RST;
      hold_cnt_q  <= '0;
      stab_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      retry_q     <= 2'd0;
      idsel_q     <= DEF_IDSEL;
      fbdsel_q    <= DEF_FBDSEL;
      odsel_q     <= DEF_ODSEL;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_q     <= retry_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      pll_reset_q <= (state_d == HOLD_RST) || (state_d == FAIL);
      // sys_rst releases one cycle after locked rises
      sys_rst_q   <= !((state_q == LOCKED) && (state_d == LOCKED));
      locked_q    <= (state_d == LOCKED);
      cfg_ready_q <= (state_d == LOCKED) || (state_d == FAIL);
      error_q     <= (state_d == FAIL);
      busy_q      <= (state_d == HOLD_RST) || (state_d == WAIT_LOCK) || (state_d == STABLE);
    end
  end

`ifdef RPLL_LOL_COUNT_EN
  logic [7:0] lol_q;

  // Saturating count of loss-of-lock recoveries out of LOCKED
  always_ff @(posedge clkin) begin
    if (reset) lol_q <= 8'd0;
    else if (lol_evt && lol_q != 8'hFF) lol_q <= lol_q + 8'd1;
  end

  assign lol_count = lol_q;
`else
  logic unused_lol;
  assign unused_lol = lol_evt;
`endif

  assign cfg_ready  = cfg_ready_q;
  assign pll_reset  = pll_reset_q;
  assign pll_idsel  = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel  = odsel_q;
  assign locked     = locked_q;
  assign sys_rst    = sys_rst_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign retry_cnt  = retry_q;

endmodule
